systolic_skew_feeder: RTL and testbench

Edge feeder for the systolic PE array. It accepts one LANES-wide operand vector per handshake and delays lane i by i+1 array advances, producing the diagonal wavefront the array needs. It generates the array-wide enable and flushes zeros after the last vector. One instance drives the west edge (A rows) and one drives the north edge (B columns); both are started together.

---
 rtl/feeder_pkg.sv | 21 ++
 rtl/skew_delay_line.sv | 33 +++
 rtl/systolic_skew_feeder.sv | 117 +++++++++++
 tb/tb_systolic_skew_feeder.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/feeder_pkg.sv
// Shared types for the systolic edge feeders and the array top.
// State encoding plus the lane packing helper.
package feeder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int FEEDER_WIDTH = 16;

  function automatic int lane_lo(
    input int lane,
    input int width
  );
    return lane * width;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// One skew lane: DEPTH registers shifted on en.
// clr zeroes the whole chain synchronously.
module skew_delay_line #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sr [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++)
        sr[k] <= '0;
    end else if (clr) begin
      for (int k = 0; k < DEPTH; k++)
        sr[k] <= '0;
    end else if (en) begin
      sr[0] <= d;
      for (int k = 1; k < DEPTH; k++)
        sr[k] <= sr[k-1];
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Skewing edge feeder for the systolic PE array.
// Optional stall counter output: define FEEDER_STALL_CNT_EN.
module systolic_skew_feeder
  import feeder_pkg::*;
#(
  parameter int WIDTH = FEEDER_WIDTH,
  parameter int LANES = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CNT_W-1:0]       len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic                   arr_ena,
  output logic                   busy,
  output logic                   done
`ifdef FEEDER_STALL_CNT_EN
  ,
  output logic [15:0]            stall_cnt
`endif
);

  state_e           state;
  state_e           state_nx;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] flush;
  logic             adv;
  logic             last_acc;

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    adv      = 1'b0;
    last_acc = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start)
          state_nx = (len != '0) ? STREAM : DONE;
      end
      STREAM: begin
        in_ready = 1'b1;
        adv      = in_valid;
        last_acc = in_valid && (remaining == CNT_W'(1));
        if (last_acc)
          state_nx = (LANES == 1) ? DONE : FLUSH;
      end
      FLUSH: begin
        adv = 1'b1;
        if (flush == CNT_W'(1))
          state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      flush     <= '0;
      arr_ena   <= 1'b0;
    end else begin
      state   <= state_nx;
      arr_ena <= adv;
      if (state == IDLE && start)
        remaining <= len;
      else if (in_ready && in_valid)
        remaining <= remaining - CNT_W'(1);
      if (last_acc)
        flush <= CNT_W'(LANES - 1);
      else if (state == FLUSH && flush != '0)
        flush <= flush - CNT_W'(1);
    end
  end

  // Lane i is i+1 deep so vector j reaches PE column i on pulse j+i+1.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [WIDTH-1:0] d;
    assign d = (state == FLUSH) ? '0
             : in_data[lane_lo(i, WIDTH) +: WIDTH];
    skew_delay_line #(
      .WIDTH(WIDTH),
      .DEPTH(i + 1)
    ) u_dl (
      .clk(clk),
      .rst(rst),
      .en (adv),
      .clr(state == DONE),
      .d  (d),
      .q  (out_data[lane_lo(i, WIDTH) +: WIDTH])
    );
  end

`ifdef FEEDER_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (state == IDLE && start)
      stall_cnt <= '0;
    else if (state == STREAM && !in_valid
             && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: vector table plus
// randomized tiles checked against a wavefront model.
module tb_systolic_skew_feeder;

  localparam int WIDTH = 16;
  localparam int LANES = 4;
  localparam int CNT_W = 8;
  localparam int DW    = WIDTH * LANES;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DW-1:0]    in_data = '0;
  logic [DW-1:0]    out_data;
  logic             arr_ena;
  logic             busy;
  logic             done;
`ifdef FEEDER_STALL_CNT_EN
  logic [15:0]      stall_cnt;
`endif

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] vecs[$];
  logic [DW-1:0] pulses[$];

  always #5 clk = ~clk;

  systolic_skew_feeder #(
    .WIDTH(WIDTH),
    .LANES(LANES),
    .CNT_W(CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .len     (len),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data (in_data),
    .out_data(out_data),
    .arr_ena (arr_ena),
    .busy    (busy),
    .done    (done)
`ifdef FEEDER_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  task automatic chk(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  // Pulse p (1-based) carries vector p-1-i on lane i.
  function automatic logic [DW-1:0] exp_vec(input int p);
    logic [DW-1:0] v;
    int j;
    v = '0;
    for (int i = 0; i < LANES; i++) begin
      j = p - 1 - i;
      if (j >= 0 && j < vecs.size())
        v[i*WIDTH +: WIDTH] = vecs[j][i*WIDTH +: WIDTH];
    end
    return v;
  endfunction

  function automatic logic [DW-1:0] rnd_vec();
    return {$urandom, $urandom};
  endfunction

  task automatic load_fixed();
    vecs.delete();
    vecs.push_back({16'd4, 16'd3, 16'd2, 16'd1});
    vecs.push_back({16'd8, 16'd7, 16'd6, 16'd5});
    vecs.push_back({16'd12, 16'd11, 16'd10, 16'd9});
  endtask

  task automatic load_rand(input int k);
    vecs.delete();
    for (int i = 0; i < k; i++)
      vecs.push_back(rnd_vec());
  endtask

  // mode 0: no stalls, 1: two stalls after vector 0,
  // 2: random stalls. abort>0 resets on that flush cycle.
  task automatic run_tile(
    input int k,
    input int mode,
    input bit mid,
    input int abort,
    input int exp_pulses
  );
    int idx, gap, stalls, busy_cyc, ndone;
    int done_pulse, since;
    bit acc_all, after_done, finished, saw_ready;
    bit done_ena, v;
    logic [DW-1:0] prev;
    idx = 0; gap = 0; stalls = 0; busy_cyc = 0;
    ndone = 0; done_pulse = -1; since = 0;
    acc_all = 0; after_done = 0; finished = 0;
    saw_ready = 0; done_ena = 0;
    pulses.delete();
    @(negedge clk);
    prev  = out_data;
    start = 1'b1;
    len   = CNT_W'(k);
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      if (after_done) begin
        chk("busy_after_done", 64'(busy), 64'd0);
        chk("cleared_after_done", out_data, 64'd0);
`ifdef FEEDER_STALL_CNT_EN
        chk("stall_cnt_hold", 64'(stall_cnt),
            64'(stalls));
`endif
        finished = 1;
        break;
      end
      if (busy) busy_cyc++;
      if (in_ready) saw_ready = 1;
      if (arr_ena) pulses.push_back(out_data);
      else chk("hold_no_ena", out_data, prev);
      if (done) begin
        ndone++;
        done_pulse = pulses.size();
        done_ena = arr_ena;
        after_done = 1;
      end
      prev = out_data;
      if (acc_all) since++;
      if (abort != 0 && since == abort) begin
        rst = 1'b1;
        #1;
        chk("abort_out", out_data, 64'd0);
        chk("abort_ena", 64'(arr_ena), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
`ifdef FEEDER_STALL_CNT_EN
        chk("abort_stall", 64'(stall_cnt), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (3) begin
          @(negedge clk);
          if (done) ndone++;
        end
        chk("abort_no_done", 64'(ndone), 64'd0);
        return;
      end
      start    = mid && in_ready && idx == 1;
      len      = start ? CNT_W'(9) : '0;
      in_valid = 1'($urandom_range(0, 1));
      in_data  = rnd_vec();
      if (in_ready && idx < k) begin
        case (mode)
          0: v = 1;
          1: begin
            v = !(idx == 1 && gap < 2);
            if (!v) gap++;
          end
          default: v = $urandom_range(0, 99) >= 30;
        endcase
        in_valid = v;
        in_data  = vecs[idx];
        if (v) begin
          idx++;
          if (idx == k) acc_all = 1;
        end else begin
          stalls++;
        end
      end
    end
    start = 1'b0;
    in_valid = 1'b0;
    if (!finished) begin
      failures++;
      $display("FAIL timeout k=%0d actual=nodone required=done",
               k);
    end
    chk("done_count", 64'(ndone), 64'd1);
    chk("pulse_count", 64'(pulses.size()),
        64'(exp_pulses));
    chk("done_on_last_pulse", 64'(done_pulse),
        64'(exp_pulses));
    chk("done_with_ena", 64'(done_ena), 64'(k != 0));
    chk("busy_cycles", 64'(busy_cyc),
        64'(k == 0 ? 1 : k + stalls + LANES));
    if (k == 0)
      chk("no_ready_len0", 64'(saw_ready), 64'd0);
    for (int p = 0; p < pulses.size(); p++)
      chk($sformatf("pulse%0d", p + 1), pulses[p],
          exp_vec(p + 1));
  endtask

  typedef struct {
    int len;
    int mode;
    bit mid;
    bit fixed;
    int exp_pulses;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int l0[6];
    int l3[6];
    l0 = '{1, 5, 9, 0, 0, 0};
    l3 = '{0, 0, 0, 4, 8, 12};

    tbl[0] = '{3,   0, 1'b0, 1'b1, 6};
    tbl[1] = '{3,   1, 1'b0, 1'b1, 6};
    tbl[2] = '{0,   0, 1'b0, 1'b0, 0};
    tbl[3] = '{3,   0, 1'b1, 1'b1, 6};
    tbl[4] = '{1,   0, 1'b0, 1'b0, 4};
    tbl[5] = '{8,   2, 1'b0, 1'b0, 11};
    tbl[6] = '{20,  2, 1'b1, 1'b0, 23};
    tbl[7] = '{255, 2, 1'b0, 1'b0, 258};

    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = {LANES{16'hFFFF}};
    repeat (3) @(negedge clk);
    chk("rst_out", out_data, 64'd0);
    chk("rst_ena", 64'(arr_ena), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd0);
`ifdef FEEDER_STALL_CNT_EN
    chk("rst_stall", 64'(stall_cnt), 64'd0);
`endif
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_ready", 64'(in_ready), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    in_valid = 1'b0;

    for (int t = 0; t < 8; t++) begin
      if (tbl[t].fixed) load_fixed();
      else load_rand(tbl[t].len);
      run_tile(tbl[t].len, tbl[t].mode, tbl[t].mid, 0,
               tbl[t].exp_pulses);
    end

    load_fixed();
    run_tile(3, 0, 1'b0, 0, 6);
    for (int p = 0; p < 6; p++) begin
      if (p < pulses.size()) begin
        chk($sformatf("lane0_p%0d", p + 1),
            64'(pulses[p][15:0]), 64'(l0[p]));
        chk($sformatf("lane3_p%0d", p + 1),
            64'(pulses[p][63:48]), 64'(l3[p]));
      end
    end

    load_fixed();
    run_tile(3, 1, 1'b0, 0, 6);
`ifdef FEEDER_STALL_CNT_EN
    chk("stall_cnt_two", 64'(stall_cnt), 64'd2);
`endif

    load_fixed();
    run_tile(3, 0, 1'b0, 2, 6);

    vecs.delete();
    vecs.push_back({4{16'd7}});
    run_tile(1, 0, 1'b0, 0, 4);
    for (int p = 0; p < pulses.size(); p++)
      for (int i = 0; i < LANES; i++)
        chk($sformatf("sevens_p%0d_l%0d", p + 1, i),
            64'(pulses[p][i*WIDTH +: WIDTH]),
            (p == i) ? 64'd7 : 64'd0);

    for (int r = 0; r < 6; r++) begin
      int k;
      k = $urandom_range(1, 12);
      load_rand(k);
      run_tile(k, 2, 1'b0, 0, k + LANES - 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
